// File: rtl/interrupt_controller.sv
`timescale 1ns/1ps
// Purpose: synchronise external interrupt lines, latch edges or follow levels, and report the lowest eligible line.
// Latency: input change -> outputs after SYNC_STAGES+2 rising edges; mask/enable/ack change -> outputs after 1 edge.
// Backpressure: none; edge requests stay pending until acknowledged, and level requests follow the line.
//
// Ports:
//   clock, reset                  - system clock, async active-high reset
//   externalInterruptLines        - raw asynchronous request lines
//   edgeModeMask                  - per line: 1 = edge-triggered (latched), 0 = level-triggered
//   pswInterruptMask/Enable       - per-line and global enables from the PSW
//   acknowledge/acknowledgeIndex  - one-cycle strobe clearing a latched edge request
//   interruptActive, index        - registered "some line eligible" flag and lowest eligible line
//   pendingLines                  - registered pending vector before masking
module interrupt_controller #(
  parameter int LINE_COUNT  = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LINE_COUNT-1:0]  externalInterruptLines,
  input  logic [LINE_COUNT-1:0]  edgeModeMask,
  input  logic [LINE_COUNT-1:0]  pswInterruptMask,
  input  logic                   pswInterruptEnable,
  input  logic                   acknowledge,
  input  logic [INDEX_WIDTH-1:0] acknowledgeIndex,
  output logic                   interruptActive,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [LINE_COUNT-1:0]  pendingLines
);

  logic [LINE_COUNT-1:0]  syncStages [SYNC_STAGES];
  logic [LINE_COUNT-1:0]  syncedLines;
  logic [LINE_COUNT-1:0]  prevSample;
  logic [LINE_COUNT-1:0]  pending;
  logic [LINE_COUNT-1:0]  risingEdges;
  logic [LINE_COUNT-1:0]  ackHit;
  logic [LINE_COUNT-1:0]  nextPending;
  logic [LINE_COUNT-1:0]  eligible;
  logic [INDEX_WIDTH-1:0] lowestIndex;

  assign syncedLines = syncStages[SYNC_STAGES-1];

  // prevSample resets to 0, so a line already high at reset release counts as one rising edge.
  assign risingEdges = syncedLines & ~prevSample;

  // Shifting past the vector width yields zero, so out-of-range ack indices hit nothing.
  assign ackHit = acknowledge ? (LINE_COUNT'(1) << acknowledgeIndex) : '0;

  // A fresh edge in the same cycle as its ack keeps the request set.
  assign nextPending = (edgeModeMask  & (risingEdges | (pending & ~ackHit)))
                     | (~edgeModeMask & syncedLines);

  assign eligible = pending & pswInterruptMask & {LINE_COUNT{pswInterruptEnable}};

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    lowestIndex = '0;
    for (int i = LINE_COUNT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lowestIndex = INDEX_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncStages[s] <= '0;
      end
      prevSample      <= '0;
      pending         <= '0;
      interruptActive <= 1'b0;
      index           <= '0;
      pendingLines    <= '0;
    end else begin
      syncStages[0] <= externalInterruptLines;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncStages[s] <= syncStages[s-1];
      end
      prevSample      <= syncedLines;
      pending         <= nextPending;
      interruptActive <= |eligible;
      index           <= lowestIndex;
      pendingLines    <= pending;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for interrupt_controller (16 lines, 2 sync stages, 20 ns clock).
// Latency: inputs are driven just after a falling edge and outputs sampled on falling edges.
// Backpressure: not applicable; every wait is a fixed number of cycles.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] externalInterruptLines = '0;
  logic [15:0] edgeModeMask = '0;
  logic [15:0] pswInterruptMask = 16'hFFFF;
  logic        pswInterruptEnable = 1'b1;
  logic        acknowledge = 1'b0;
  logic [3:0]  acknowledgeIndex = '0;
  logic        interruptActive;
  logic [3:0]  index;
  logic [15:0] pendingLines;

  int testCount = 0;
  int failCount = 0;

  always #10 clock = ~clock;

  interrupt_controller #(
    .LINE_COUNT (16),
    .INDEX_WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .externalInterruptLines(externalInterruptLines),
    .edgeModeMask          (edgeModeMask),
    .pswInterruptMask      (pswInterruptMask),
    .pswInterruptEnable    (pswInterruptEnable),
    .acknowledge           (acknowledge),
    .acknowledgeIndex      (acknowledgeIndex),
    .interruptActive       (interruptActive),
    .index                 (index),
    .pendingLines          (pendingLines)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Each call passes exactly n rising edges and returns on a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ackLine(input logic [3:0] line);
    acknowledge      = 1'b1;
    acknowledgeIndex = line;
    cycles(1);
    acknowledge      = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    checkValue("rst_active", interruptActive, 0);
    checkValue("rst_index", index, 0);
    checkValue("rst_pending", pendingLines, 0);
    @(negedge clock);
    reset = 1'b0;
    cycles(2);

    // Level mode, lines 5 and 8
    externalInterruptLines[5] = 1'b1;
    cycles(3);
    checkValue("lvl_active_3edges", interruptActive, 0);
    cycles(1);
    checkValue("lvl_active_4edges", interruptActive, 1);
    checkValue("lvl_index5", index, 5);
    externalInterruptLines[8] = 1'b1;
    cycles(4);
    checkValue("lvl_index_stays5", index, 5);
    checkValue("lvl_pending_5_8", pendingLines, 16'h0120);
    externalInterruptLines[5] = 1'b0;
    cycles(3);
    checkValue("lvl_index_still5_3edges", index, 5);
    cycles(1);
    checkValue("lvl_index8", index, 8);
    checkValue("lvl_active_8", interruptActive, 1);
    externalInterruptLines[8] = 1'b0;
    cycles(4);
    checkValue("lvl_all_low", interruptActive, 0);

    // Edge mode, line 3: one-cycle pulse latches
    edgeModeMask = 16'h0008;
    externalInterruptLines[3] = 1'b1;
    cycles(1);
    externalInterruptLines[3] = 1'b0;
    cycles(4);
    checkValue("edge_active", interruptActive, 1);
    checkValue("edge_index3", index, 3);
    checkValue("edge_pending", pendingLines, 16'h0008);
    ackLine(4'd7);
    cycles(1);
    checkValue("edge_wrong_ack", interruptActive, 1);
    ackLine(4'd3);
    cycles(1);
    checkValue("edge_ack_clears", interruptActive, 0);
    checkValue("edge_ack_pending", pendingLines, 0);

    // Edge mode, line 3: new edge in the same cycle as its ack keeps it pending
    externalInterruptLines[3] = 1'b1;
    cycles(1);
    externalInterruptLines[3] = 1'b0;
    cycles(5);
    checkValue("race_pre_active", interruptActive, 1);
    externalInterruptLines[3] = 1'b1;
    cycles(2);
    ackLine(4'd3);
    cycles(1);
    checkValue("race_pending3", pendingLines[3], 1);
    checkValue("race_active", interruptActive, 1);
    externalInterruptLines[3] = 1'b0;
    ackLine(4'd3);
    cycles(2);
    checkValue("race_cleanup", interruptActive, 0);

    // Masking and global enable with lines 5 and 8 level-high
    edgeModeMask = '0;
    externalInterruptLines = 16'h0120;
    cycles(4);
    checkValue("mask_start_index", index, 5);
    pswInterruptEnable = 1'b0;
    cycles(1);
    checkValue("mask_disable", interruptActive, 0);
    pswInterruptEnable = 1'b1;
    cycles(1);
    checkValue("mask_reenable_active", interruptActive, 1);
    checkValue("mask_reenable_index", index, 5);
    pswInterruptMask = 16'hFFDF;
    cycles(1);
    checkValue("mask_FFDF_index", index, 8);
    pswInterruptMask = 16'hFEDF;
    cycles(1);
    checkValue("mask_FEDF_active", interruptActive, 0);
    checkValue("mask_FEDF_index", index, 0);
    pswInterruptMask = 16'hFEFF;
    cycles(1);
    checkValue("mask_FEFF_index", index, 5);
    checkValue("mask_FEFF_active", interruptActive, 1);
    externalInterruptLines = '0;
    pswInterruptMask = 16'hFFFF;
    cycles(4);

    // Edge line 2 latched while masked
    edgeModeMask = 16'h0004;
    pswInterruptMask = 16'hFFFB;
    externalInterruptLines[2] = 1'b1;
    cycles(1);
    externalInterruptLines[2] = 1'b0;
    cycles(4);
    checkValue("masked_pending", pendingLines, 16'h0004);
    checkValue("masked_inactive", interruptActive, 0);
    pswInterruptMask = 16'hFFFF;
    cycles(1);
    checkValue("unmask_active", interruptActive, 1);
    checkValue("unmask_index", index, 2);

    // Asynchronous reset mid-cycle discards the latched edge
    #5 reset = 1'b1;
    #1;
    checkValue("arst_active", interruptActive, 0);
    checkValue("arst_index", index, 0);
    checkValue("arst_pending", pendingLines, 0);
    @(negedge clock);
    reset = 1'b0;
    cycles(4);
    checkValue("arst_after_pending", pendingLines, 0);
    checkValue("arst_after_active", interruptActive, 0);

    // Line 4 held high through reset registers one latched edge
    edgeModeMask = 16'h0014;
    externalInterruptLines[4] = 1'b1;
    cycles(3);
    #5 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    cycles(4);
    checkValue("held_active", interruptActive, 1);
    checkValue("held_index4", index, 4);
    checkValue("held_pending", pendingLines, 16'h0010);
    ackLine(4'd4);
    cycles(1);
    checkValue("held_ack_clears", interruptActive, 0);
    cycles(4);
    checkValue("held_no_relatch", pendingLines, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Parametrised successor to the CPU's interrupt detector. Synchronises LINE_COUNT asynchronous external interrupt lines and supports per-line level or edge (latched) triggering. Edge-triggered lines are cleared by an explicit acknowledge handshake. Gates pending lines with the PSW mask and enable, and presents a registered "interrupt active" flag plus the lowest-numbered eligible line to the CPU control unit.

Parameters:
LINE_COUNT, 16, number of interrupt lines (2..32).
INDEX_WIDTH, 4, width of index ports; must equal ceil(log2(LINE_COUNT)).
SYNC_STAGES, 2, synchroniser flip-flops per line (1..3).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
externalInterruptLines  input  LINE_COUNT  raw asynchronous request lines
edgeModeMask  input  LINE_COUNT  per line: 1 = edge-triggered (latched), 0 = level-triggered
pswInterruptMask  input  LINE_COUNT  per-line enable from PSW
pswInterruptEnable  input  1  global interrupt enable from PSW
acknowledge  input  1  one-cycle strobe; clears the latched edge request of acknowledgeIndex
acknowledgeIndex  input  INDEX_WIDTH  line being acknowledged
interruptActive  output  1  registered: some pending line is enabled and unmasked
index  output  INDEX_WIDTH  registered: lowest eligible line number
pendingLines  output  LINE_COUNT  registered pending vector (before masking), for debug/PSW readback

Behaviour:
- Reset (async, any time): synchroniser stages, previous-sample register, pending, interruptActive and index all go to 0. A mid-operation reset discards all latched edges.
- Synchroniser: per line, a SYNC_STAGES-deep shift register; s = last stage. A previous-sample register p samples s each cycle.
- Rising edge detected when s & ~p. Because p resets to 0, a line that is high at reset release registers as one rising edge.
- Pending update, every cycle, per line i:
  - Level mode: pending[i] <= s[i]. Acknowledge has no effect.
  - Edge mode: pending[i] <= rise[i] | (pending[i] & ~ackHit[i]), where ackHit[i] = acknowledge & (acknowledgeIndex == i). A new edge in the same cycle as ack wins: the bit stays set.
- acknowledgeIndex >= LINE_COUNT, or an ack of a non-pending line: no effect.
- Mode switch edge to level: pending follows s from the next cycle, so a stale latched edge is dropped if the line is low. Switch level to edge: current pending value is retained as latched.
- Eligible vector: e = pending & pswInterruptMask & {LINE_COUNT{pswInterruptEnable}}.
- Output registers:
  - interruptActive <= |e.
  - index <= lowest i with e[i] = 1, or 0 when e = 0.
  - pendingLines <= pending.
- Masked or disabled edge lines stay pending and become active once unmasked.
- Latency from an input change, level or edge mode: sampled at edge 1, visible in s at edge SYNC_STAGES, in pending at SYNC_STAGES+1, on outputs at SYNC_STAGES+2. Default is 4 rising edges.
- Latency from a mask, enable or pending-clear change to the outputs: 1 rising edge. An ack at edge k drops that line from the outputs at edge k+1.
- Priority is fixed: lowest index wins. A higher line never pre-empts a lower one that is still eligible.
- Pulses shorter than one clock period may be missed. This is legal and not an error.

Test Plan:
All cases: LINE_COUNT=16, SYNC_STAGES=2, 20 ns clock, mask all ones, enable=1 unless stated.
- Level mode, all lines. Raise line 5 -> interruptActive=0 after 3 edges, =1 and index=5 after 4. Raise line 8 -> index stays 5. Drop line 5 -> index=8 four edges later. Drop line 8 -> interruptActive=0.
- Edge mode, line 3. 1-cycle pulse -> interruptActive=1, index=3, held after the line returns low. acknowledge with acknowledgeIndex=3 -> interruptActive=0 next edge. Ack with acknowledgeIndex=7 instead -> no change.
- Edge mode, line 3. New rising edge arrives at s in the same cycle as an ack of line 3 -> pendingLines[3] stays 1 and interruptActive stays 1.
- Lines 5 and 8 level-high. pswInterruptEnable=0 -> interruptActive=0 within 1 edge. Re-enable -> 1, index=5. Mask 0xFFDF -> index=8. Mask 0xFEDF -> interruptActive=0. Mask 0xFEFF -> index=5.
- Edge mode, line 2 latched while masked (mask bit 2 = 0) -> pendingLines[2]=1, interruptActive=0. Unmask -> interruptActive=1, index=2 next edge.
- Edge mode, line 2 latched, then reset pulsed asynchronously mid-cycle with all lines low -> all outputs 0 immediately. After release, pendingLines=0. Line 4 held high through reset -> one latched edge appears, index=4.
